// File: rtl/gcd_pkg.sv
// Shared constants and FSM state type for the gcd dispatcher.
//   GCD_WIDTH : default operand/result width (must match the gcd core)
//   GCD_DEPTH : default operand FIFO depth
//   GCD_TAG_W : default job tag width
//   disp_state_t : dispatcher FSM state, 2-bit encoding like the core
package gcd_pkg;

    localparam int unsigned GCD_WIDTH = 8;
    localparam int unsigned GCD_DEPTH = 4;
    localparam int unsigned GCD_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } disp_state_t;

endpackage

// File: rtl/gcd_dispatch_if.sv
// Bus bundle of the gcd dispatcher: operand stream in, core command/result,
// result stream out.
//   slave  : dispatcher side (gcd_dispatch)
//   master : environment side (producer, gcd core, consumer)
interface gcd_dispatch_if
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH,
    parameter int unsigned TAG_W = GCD_TAG_W
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_A;
    logic [WIDTH-1:0] IN_B;
    logic             GCD_START;
    logic [WIDTH-1:0] GCD_A;
    logic [WIDTH-1:0] GCD_B;
    logic [WIDTH-1:0] GCD_Y;
    logic             GCD_DONE;
    logic             GCD_ERROR;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_Y;
    logic             OUT_ERR;
    logic [TAG_W-1:0] OUT_TAG;

    modport slave (
        input  IN_VALID, IN_A, IN_B, GCD_Y, GCD_DONE, GCD_ERROR, OUT_READY,
        output IN_READY, GCD_START, GCD_A, GCD_B, OUT_VALID, OUT_Y, OUT_ERR, OUT_TAG
    );

    modport master (
        output IN_VALID, IN_A, IN_B, GCD_Y, GCD_DONE, GCD_ERROR, OUT_READY,
        input  IN_READY, GCD_START, GCD_A, GCD_B, OUT_VALID, OUT_Y, OUT_ERR, OUT_TAG
    );

endinterface

// File: rtl/gcd_op_fifo.sv
// Synchronous FIFO of operand pairs for the gcd dispatcher.
//   CLK, RST  : clock, asynchronous active-high reset (empties the FIFO)
//   push_i    : write data_i (ignored when full)
//   pop_i     : drop the head entry (ignored when empty)
//   head_o    : current head entry
//   full_o, empty_o : occupancy flags from registered pointers
module gcd_op_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic              do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
        end
    end

    // Storage, no reset needed: contents are qualified by the pointers.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/gcd_dispatch.sv
// Feeder and result collector for the gcd core: buffers operand pairs,
// issues one job at a time with a one-cycle GCD_START, and holds each
// result with a wrapping job tag until the consumer accepts it.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : gcd_dispatch_if.slave (IN_*, GCD_*, OUT_* signals)
// Build option GCD_ZERO_BYPASS_EN: pairs with a zero operand are answered
// directly from IDLE with OUT_ERR=1, without starting the core.
module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH,
    parameter int unsigned DEPTH = GCD_DEPTH,
    parameter int unsigned TAG_W = GCD_TAG_W
) (
    input logic           CLK,
    input logic           RST,
    gcd_dispatch_if.slave bus
);
    localparam int unsigned PAIR_W = 2 * WIDTH;

    disp_state_t      state_q, state_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic             out_err_q, out_err_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rdy_q;

    logic [PAIR_W-1:0] head;
    logic [WIDTH-1:0]  head_a, head_b;
    logic              full, empty, push, pop, in_ready, head_zero;

    // rdy_q keeps IN_READY low while reset is asserted.
    assign in_ready = rdy_q && !full;
    assign push     = bus.IN_VALID && in_ready;
    assign head_a   = head[PAIR_W-1:WIDTH];
    assign head_b   = head[WIDTH-1:0];

`ifdef GCD_ZERO_BYPASS_EN
    assign head_zero = (head_a == '0) || (head_b == '0);
`else
    assign head_zero = 1'b0;
`endif

    gcd_op_fifo #(
        .DATA_W (PAIR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({bus.IN_A, bus.IN_B}),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            gcd_a_q     <= '0;
            gcd_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_err_q   <= 1'b0;
            out_tag_q   <= '0;
            tag_q       <= '0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            gcd_a_q     <= gcd_a_d;
            gcd_b_q     <= gcd_b_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_err_q   <= out_err_d;
            out_tag_q   <= out_tag_d;
            tag_q       <= tag_d;
            rdy_q       <= 1'b1;
        end
    end

    // Next-state logic; a held result blocks the next issue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty && !out_valid_q && !head_zero) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.GCD_DONE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic; DONE outside WAIT is ignored.
    always_comb begin
        pop         = 1'b0;
        start_d     = 1'b0;
        gcd_a_d     = gcd_a_q;
        gcd_b_d     = gcd_b_q;
        out_valid_d = out_valid_q && !bus.OUT_READY;
        out_y_d     = out_y_q;
        out_err_d   = out_err_q;
        out_tag_d   = out_tag_q;
        tag_d       = tag_q;
        case (state_q)
            IDLE: begin
                if (!empty && !out_valid_q) begin
                    pop = 1'b1;
                    if (head_zero) begin
                        out_valid_d = 1'b1;
                        out_y_d     = '0;
                        out_err_d   = 1'b1;
                        out_tag_d   = tag_q;
                        tag_d       = tag_q + TAG_W'(1);
                    end else begin
                        gcd_a_d = head_a;
                        gcd_b_d = head_b;
                        start_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (bus.GCD_DONE) begin
                    out_valid_d = 1'b1;
                    out_y_d     = bus.GCD_ERROR ? '0 : bus.GCD_Y;
                    out_err_d   = bus.GCD_ERROR;
                    out_tag_d   = tag_q;
                    tag_d       = tag_q + TAG_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.IN_READY  = in_ready;
    assign bus.GCD_START = start_q;
    assign bus.GCD_A     = gcd_a_q;
    assign bus.GCD_B     = gcd_b_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_Y     = out_y_q;
    assign bus.OUT_ERR   = out_err_q;
    assign bus.OUT_TAG   = out_tag_q;

endmodule

// File: tb/tb_gcd_dispatch.sv
// Self-checking bench for gcd_dispatch with a behavioural gcd core stub.
module tb_gcd_dispatch;
    localparam int unsigned W  = 8;
    localparam int unsigned TW = 4;

    typedef struct packed {
        logic [W-1:0]  y;
        logic          err;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gcd_dispatch_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    gcd_dispatch #(.WIDTH(W), .DEPTH(4), .TAG_W(TW)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    exp_t          sb[$];
    logic [TW-1:0] exp_tag = '0;

    task automatic sb_push(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.err = (a == 0) || (b == 0);
        e.y   = e.err ? '0 : ref_gcd(a, b);
        e.tag = exp_tag;
        exp_tag = exp_tag + TW'(1);
        sb.push_back(e);
    endtask

    // ---------------- gcd core stub ----------------
    int           start_cnt = 0;
    bit           inject_idle = 0, inject_on_start = 0, chk_hold = 1;
    int           lat_fix = -1;
    bit           busy = 0, prev_start = 0, lat_pend = 0;
    int           cnt = 0;
    logic [W-1:0] sa = '0, sbv = '0;

    initial begin
        bus.GCD_DONE  = 1'b0;
        bus.GCD_Y     = '0;
        bus.GCD_ERROR = 1'b0;
        forever begin
            @(negedge clk);
            if (lat_pend) begin
                chk("done_to_valid", 32'(bus.OUT_VALID), 32'(1));
                lat_pend = 0;
            end
            bus.GCD_DONE  = 1'b0;
            bus.GCD_ERROR = 1'b0;
            bus.GCD_Y     = '0;
            if (inject_idle) begin
                bus.GCD_DONE = 1'b1;
                bus.GCD_Y    = 8'h5A;
                inject_idle  = 0;
            end else if (busy) begin
                if (cnt == 0) begin
                    busy = 0;
                    bus.GCD_DONE = 1'b1;
                    if (sa == 0 || sbv == 0) begin
                        bus.GCD_ERROR = 1'b1;
                        bus.GCD_Y     = 8'hEE;
                    end else begin
                        bus.GCD_Y = ref_gcd(sa, sbv);
                    end
                    if (chk_hold) begin
                        chk("ops_held", 32'({bus.GCD_A, bus.GCD_B}), 32'({sa, sbv}));
                        lat_pend = 1;
                    end
                end else begin
                    cnt--;
                end
            end
            if (bus.GCD_START) begin
                chk("start_one_cycle", 32'(prev_start), 32'(0));
                start_cnt++;
                busy = 1;
                sa   = bus.GCD_A;
                sbv  = bus.GCD_B;
                cnt  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
                if (inject_on_start) begin
                    bus.GCD_DONE    = 1'b1;
                    bus.GCD_Y       = 8'h5A;
                    inject_on_start = 0;
                end
            end
            prev_start = bus.GCD_START;
        end
    end

    // ---------------- result monitor ----------------
    bit          hold_pend = 0;
    logic [12:0] held = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.OUT_VALID) begin
                if (hold_pend)
                    chk("out_stable", 32'({bus.OUT_Y, bus.OUT_ERR, bus.OUT_TAG}), 32'(held));
                if (bus.OUT_READY) begin
                    hold_pend = 0;
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 32'(0), 32'(1));
                    end else begin
                        e = sb.pop_front();
                        chk("out_y",   32'(bus.OUT_Y),   32'(e.y));
                        chk("out_err", 32'(bus.OUT_ERR), 32'(e.err));
                        chk("out_tag", 32'(bus.OUT_TAG), 32'(e.tag));
                    end
                end else begin
                    hold_pend = 1;
                    held = {bus.OUT_Y, bus.OUT_ERR, bus.OUT_TAG};
                end
            end else begin
                hold_pend = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bus.IN_VALID = 1'b1;
        bus.IN_A     = a;
        bus.IN_B     = b;
        @(negedge clk);
        while (!bus.IN_READY && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.IN_READY) chk("push_timeout", 32'(0), 32'(1));
        else sb_push(a, b);
        @(posedge clk);
        #1 bus.IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [W-1:0] ba [5] = '{8'd48, 8'd7, 8'd100, 8'd9, 8'd255};
    logic [W-1:0] bb [5] = '{8'd18, 8'd5, 8'd75,  8'd9, 8'd17};

    initial begin
        int s0, n;
        bus.IN_VALID  = 1'b0;
        bus.IN_A      = '0;
        bus.IN_B      = '0;
        bus.OUT_READY = 1'b1;

        // Reset values.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.IN_READY),  32'(0));
        chk("rst_out_valid", 32'(bus.OUT_VALID), 32'(0));
        chk("rst_start",     32'(bus.GCD_START), 32'(0));
        chk("rst_gcd_ab",    32'({bus.GCD_A, bus.GCD_B}), 32'(0));
        chk("rst_out_y",     32'(bus.OUT_Y),     32'(0));
        chk("rst_out_err",   32'(bus.OUT_ERR),   32'(0));
        chk("rst_out_tag",   32'(bus.OUT_TAG),   32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.IN_READY), 32'(1));
        @(posedge clk);
        #1;

        // Single job (12,8) -> 4, tag 0.
        s0 = start_cnt;
        push_pair(8'd12, 8'd8);
        drain();
        chk("t1_start_count", 32'(start_cnt - s0), 32'(1));

        // Zero operand job.
        s0 = start_cnt;
        push_pair(8'd0, 8'd9);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.OUT_VALID && n < 100);
`ifdef GCD_ZERO_BYPASS_EN
        chk("bypass_latency", 32'(n), 32'(2));
        chk("bypass_no_start", 32'(start_cnt - s0), 32'(0));
`else
        chk("zero_via_core", 32'(start_cnt - s0), 32'(1));
`endif
        @(posedge clk);
        #1;
        drain();

        // Spurious DONE in IDLE, then in ISSUE.
        inject_idle = 1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_done_ignored", 32'(bus.OUT_VALID), 32'(0));
        end
        @(posedge clk);
        #1;
        inject_on_start = 1;
        push_pair(8'd21, 8'd14);
        drain();

        // Back-to-back burst with the consumer stalled.
        bus.OUT_READY = 1'b0;
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) push_pair(ba[i], bb[i]);
        n = 0;
        while (!bus.OUT_VALID && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("burst_first_done", 32'(bus.OUT_VALID), 32'(1));
        repeat (5) @(negedge clk);
        chk("burst_full_ready", 32'(bus.IN_READY), 32'(0));
        chk("burst_one_start",  32'(start_cnt - s0), 32'(1));
        @(posedge clk);
        #1 bus.OUT_READY = 1'b1;
        drain();
        chk("burst_all_started", 32'(start_cnt - s0), 32'(5));

        // Reset while the core works on (200,150).
        lat_fix = 30;
        push_pair(8'd200, 8'd150);
        n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk_hold = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        exp_tag = '0;
        @(negedge clk);
        chk("mid_rst_in_ready",  32'(bus.IN_READY),  32'(0));
        chk("mid_rst_out_valid", 32'(bus.OUT_VALID), 32'(0));
        chk("mid_rst_gcd_ab",    32'({bus.GCD_A, bus.GCD_B}), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rel_in_ready", 32'(bus.IN_READY), 32'(1));
        s0 = start_cnt;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) begin
            @(negedge clk);
            chk("late_done_ignored", 32'(bus.OUT_VALID), 32'(0));
        end
        chk("rst_fifo_empty", 32'(start_cnt - s0), 32'(0));
        chk_hold = 1;
        lat_fix  = -1;
        @(posedge clk);
        #1;

        // 17 jobs: tags 0..15 then wrap to 0.
        for (int i = 0; i < 17; i++) push_pair(8'((i + 1) * 6), 8'((i + 2) * 4));
        drain();
        chk("tag_wrap", 32'(bus.OUT_TAG), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

endmodule
